// File: rtl/vfu_pkg.sv
// Shared constants and instruction classification for the CFU <-> vector-core bridge.
package vfu_pkg;

  localparam logic [6:0] OP_V         = 7'h57;
  localparam logic [2:0] F3_OPMVV     = 3'b010;
  localparam logic [5:0] F6_VWXUNARY0 = 6'b010000;

  typedef enum logic {
    RSP_ACK    = 1'b0,
    RSP_SCALAR = 1'b1
  } rsp_kind_e;

  // vmv.x.s / vcpop.m / vfirst.m family: the only instructions that return a scalar.
  function automatic logic is_scalar_result(input logic [31:0] insn);
    return (insn[6:0] == OP_V) && (insn[14:12] == F3_OPMVV) && (insn[31:26] == F6_VWXUNARY0);
  endfunction

endpackage

// File: rtl/vfu_cmd_bridge_if.sv
// CFU command/response bus; master is the CPU side, slave is the bridge.
interface vfu_cmd_bridge_if #(
  parameter int XLEN       = 32,
  parameter int INSN_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [INSN_WIDTH-1:0] cmd_payload_instruction;
  logic [XLEN-1:0]       cmd_payload_inputs_0;
  logic [XLEN-1:0]       cmd_payload_inputs_1;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_payload_output;

  modport master (
    output cmd_valid, cmd_payload_instruction, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_output
  );

  modport slave (
    input  cmd_valid, cmd_payload_instruction, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_output
  );
endinterface

// File: rtl/vfu_fifo_chk.sv
// Simulation-only protocol checks for vfu_sync_fifo.
module vfu_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));
endmodule

// File: rtl/vfu_sync_fifo.sv
// Registered synchronous FIFO, first word visible at head_data; pointers carry an extra wrap bit.
module vfu_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] MSB_ONLY = PW'(1) << (PW - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  generate
    if (DEPTH > 1) begin : g_idx
      assign wr_idx_s = wr_ptr_r[AW-1:0];
      assign rd_idx_s = rd_ptr_r[AW-1:0];
    end else begin : g_idx_single
      assign wr_idx_s = 1'b0;
      assign rd_idx_s = 1'b0;
    end
  endgenerate

  // Storage and pointer update; memory is cleared so the head never shows stale data after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_r[wr_idx_s] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  assign head_data = mem_r[rd_idx_s];
  assign count     = wr_ptr_r - rd_ptr_r;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = ((wr_ptr_r ^ rd_ptr_r) == MSB_ONLY);

  vfu_fifo_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: rtl/vfu_cmd_bridge.sv
// CFU <-> vector-core bridge: one in-order response per command, zero acks for non-scalar
// instructions, and credit-reserved buffering for core scalar results (the core cannot stall).
module vfu_cmd_bridge import vfu_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int INSN_WIDTH = 32,
  parameter int ORD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  vfu_cmd_bridge_if.slave            cfu,
  output logic                       core_insn_valid,
  input  logic                       core_insn_ready,
  output logic [INSN_WIDTH-1:0]      core_insn,
  output logic [XLEN-1:0]            core_data_1,
  output logic [XLEN-1:0]            core_data_2,
  input  logic                       core_out_valid,
  input  logic [XLEN-1:0]            core_out_data,
  output logic [$clog2(ORD_DEPTH):0] outstanding,
  output logic                       err_unexpected
);
  localparam int OCW = $clog2(ORD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;

  logic            expects_s;
  logic            credit_ok_s;
  logic            issue_ok_s;
  logic            accept_s;
  logic            pop_s;
  logic            res_push_s;
  logic            res_pop_s;
  logic            stray_s;
  logic [RCW:0]    credit_sum_s;
  logic [RCW-1:0]  owed_r;
  logic            err_r;
  logic [0:0]      ord_head_s;
  logic [OCW-1:0]  ord_count_s;
  logic            ord_full_s;
  logic            ord_empty_s;
  logic [XLEN-1:0] res_head_s;
  logic [RCW-1:0]  res_count_s;
  logic            res_full_s;
  logic            res_empty_s;
  logic            rsp_valid_s;
  logic [XLEN-1:0] rsp_payload_s;
  rsp_kind_e       head_kind_s;

  // Issue gating: a scalar-result command needs a result slot that is neither filled nor already promised.
  always_comb begin
    expects_s    = is_scalar_result(cfu.cmd_payload_instruction[31:0]);
    credit_sum_s = {1'b0, owed_r} + {1'b0, res_count_s};
    credit_ok_s  = (credit_sum_s < (RCW + 1)'(RSP_DEPTH));
    issue_ok_s   = !reset && !ord_full_s && (!expects_s || credit_ok_s);
    accept_s     = cfu.cmd_valid && core_insn_ready && issue_ok_s;
    res_push_s   = core_out_valid && (owed_r != '0);
    stray_s      = core_out_valid && (owed_r == '0);
  end

  assign cfu.cmd_ready   = core_insn_ready && issue_ok_s;
  assign core_insn_valid = cfu.cmd_valid && issue_ok_s;
  assign core_insn       = cfu.cmd_payload_instruction;
  assign core_data_1     = cfu.cmd_payload_inputs_0;
  assign core_data_2     = cfu.cmd_payload_inputs_1;

  // Response selection from the order-FIFO head.
  always_comb begin
    head_kind_s   = rsp_kind_e'(ord_head_s);
    rsp_valid_s   = 1'b0;
    rsp_payload_s = '0;
    if (ord_empty_s) begin
      rsp_valid_s   = 1'b0;
      rsp_payload_s = '0;
    end else begin
      case (head_kind_s)
        RSP_ACK: begin
          rsp_valid_s   = 1'b1;
          rsp_payload_s = '0;
        end
        RSP_SCALAR: begin
          rsp_valid_s   = !res_empty_s;
          rsp_payload_s = res_empty_s ? '0 : res_head_s;
        end
        default: begin
          rsp_valid_s   = 1'b0;
          rsp_payload_s = '0;
        end
      endcase
    end
    pop_s     = rsp_valid_s && cfu.rsp_ready;
    res_pop_s = pop_s && (head_kind_s == RSP_SCALAR);
  end

  assign cfu.rsp_valid          = rsp_valid_s;
  assign cfu.rsp_payload_output = rsp_payload_s;

  // Credits owed by the core; an accept and a delivered result in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      owed_r <= '0;
      err_r  <= 1'b0;
    end else begin
      owed_r <= owed_r + RCW'(accept_s && expects_s) - RCW'(res_push_s);
      if (stray_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign outstanding    = ord_count_s;
  assign err_unexpected = err_r;

  vfu_sync_fifo #(.WIDTH(1), .DEPTH(ORD_DEPTH)) u_ord_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept_s),
    .push_data (expects_s),
    .pop       (pop_s),
    .head_data (ord_head_s),
    .count     (ord_count_s),
    .full      (ord_full_s),
    .empty     (ord_empty_s)
  );

  vfu_sync_fifo #(.WIDTH(XLEN), .DEPTH(RSP_DEPTH)) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (res_push_s),
    .push_data (core_out_data),
    .pop       (res_pop_s),
    .head_data (res_head_s),
    .count     (res_count_s),
    .full      (res_full_s),
    .empty     (res_empty_s)
  );
endmodule

// File: tb/tb_vfu_cmd_bridge.sv
// Scoreboard bench for vfu_cmd_bridge: directed scenarios plus randomized traffic against a counting model.
module tb_vfu_cmd_bridge;
  localparam int XLEN       = 32;
  localparam int INSN_WIDTH = 32;
  localparam int ORD_DEPTH  = 4;
  localparam int RSP_DEPTH  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vfu_cmd_bridge_if #(.XLEN(XLEN), .INSN_WIDTH(INSN_WIDTH)) cfu ();

  logic                  core_insn_valid;
  logic                  core_insn_ready;
  logic [INSN_WIDTH-1:0] core_insn;
  logic [XLEN-1:0]       core_data_1;
  logic [XLEN-1:0]       core_data_2;
  logic                  core_out_valid;
  logic [XLEN-1:0]       core_out_data;
  logic [2:0]            outstanding;
  logic                  err_unexpected;

  vfu_cmd_bridge #(.XLEN(XLEN), .INSN_WIDTH(INSN_WIDTH), .ORD_DEPTH(ORD_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfu             (cfu),
    .core_insn_valid (core_insn_valid),
    .core_insn_ready (core_insn_ready),
    .core_insn       (core_insn),
    .core_data_1     (core_data_1),
    .core_data_2     (core_data_2),
    .core_out_valid  (core_out_valid),
    .core_out_data   (core_out_data),
    .outstanding     (outstanding),
    .err_unexpected  (err_unexpected)
  );

  typedef struct {
    logic [31:0] data;
    int          delay;
  } core_item_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  core_item_t  core_q[$];

  // reference model: plain counts of outstanding commands, owed results and buffered results
  int m_out = 0;
  int m_owed = 0;
  int m_buf = 0;
  bit m_kind_q[$];
  bit m_err = 1'b0;

  bit          cur_scalar = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          rsp_ready_fix = 1'b0;
  bit          core_hold = 1'b0;
  int          stray_req = 0;
  int          stray_done = 0;
  logic [31:0] p_data;
  int          p_delay;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Kinds 0..3 produce no scalar (vadd.vv, OPMVV reduction, vmv.s.x, custom opcode); 4..5 do (vmv.x.s, vcpop.m).
  function automatic logic [31:0] mk_insn(input int k);
    logic [5:0] f6;
    logic [2:0] f3;
    logic [6:0] op;
    logic [4:0] vs1;
    vs1 = 5'b00000;
    case (k)
      0:       begin f6 = 6'b000000; f3 = 3'b000; op = 7'h57; vs1 = 5'($urandom); end
      1:       begin f6 = 6'b000000; f3 = 3'b010; op = 7'h57; vs1 = 5'($urandom); end
      2:       begin f6 = 6'b010000; f3 = 3'b110; op = 7'h57; vs1 = 5'($urandom); end
      3:       begin f6 = 6'b010000; f3 = 3'b010; op = 7'h0B; end
      4:       begin f6 = 6'b010000; f3 = 3'b010; op = 7'h57; end
      default: begin f6 = 6'b010000; f3 = 3'b010; op = 7'h57; vs1 = 5'b10000; end
    endcase
    return {f6, 1'b1, 5'($urandom), vs1, f3, 5'($urandom), op};
  endfunction

  task automatic present(input int k, input logic [31:0] data, input int delay);
    cur_scalar = (k >= 4);
    p_data     = data;
    p_delay    = delay;
    cfu.cmd_payload_instruction = mk_insn(k);
    cfu.cmd_payload_inputs_0    = $urandom;
    cfu.cmd_payload_inputs_1    = $urandom;
    cfu.cmd_valid               = 1'b1;
  endtask

  task automatic wait_accept(input int max_wait);
    int  waited;
    bit  done;
    core_item_t it;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (cfu.cmd_ready) begin
        exp_q.push_back(cur_scalar ? p_data : 32'h0);
        if (cur_scalar) begin
          it.data  = p_data;
          it.delay = p_delay;
          core_q.push_back(it);
        end
        done = 1'b1;
      end else if (waited >= max_wait) begin
        chk("cmd_accept_timeout", 64'(waited), 64'(max_wait + 1));
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    tick();
    cfu.cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input int k, input logic [31:0] data, input int delay);
    present(k, data, delay);
    wait_accept(300);
  endtask

  task automatic wait_drain(input int max_cycles);
    int waited;
    waited = 0;
    while ((exp_q.size() > 0 || core_q.size() > 0) && waited < max_cycles) begin
      tick();
      waited++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'h0);
  endtask

  // ready driver
  initial begin
    cfu.rsp_ready   = 1'b0;
    core_insn_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        cfu.rsp_ready   = ($urandom_range(0, 3) != 0);
        core_insn_ready = ($urandom_range(0, 4) != 0);
      end else begin
        cfu.rsp_ready   = rsp_ready_fix;
        core_insn_ready = 1'b1;
      end
    end
  end

  // core model: returns scalar results in order after each item's delay, plus injected stray results
  initial begin
    core_item_t h;
    core_out_valid = 1'b0;
    core_out_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      core_out_valid = 1'b0;
      core_out_data  = 32'h0;
      if (stray_done != stray_req) begin
        core_out_valid = 1'b1;
        core_out_data  = 32'hBAD0_0001;
        stray_done++;
      end else if (!core_hold && !reset && core_q.size() > 0) begin
        h = core_q[0];
        if (h.delay > 0) begin
          h.delay--;
          core_q[0] = h;
        end else begin
          core_out_valid = 1'b1;
          core_out_data  = h.data;
          void'(core_q.pop_front());
        end
      end
    end
  end

  // monitor: compare DUT against the model, pop the scoreboard, then advance the model for the coming edge
  always @(negedge clk) begin : mon
    bit exp_valid;
    bit head_scalar;
    bit issue_ok;
    bit acc;
    bit pop;
    bit res;
    head_scalar = (m_kind_q.size() > 0) ? m_kind_q[0] : 1'b0;
    exp_valid   = (m_out > 0) && (!head_scalar || m_buf > 0);
    issue_ok    = !reset && (m_out < ORD_DEPTH) && (!cur_scalar || (m_owed + m_buf) < RSP_DEPTH);

    chk("outstanding", 64'(outstanding), 64'(m_out));
    chk("err_unexpected", 64'(err_unexpected), 64'(m_err));
    chk("rsp_valid", 64'(cfu.rsp_valid), 64'(exp_valid));
    chk("core_insn_valid", 64'(core_insn_valid), 64'(cfu.cmd_valid && issue_ok));
    chk("cmd_ready", 64'(cfu.cmd_ready), 64'(core_insn_ready && issue_ok));
    if (m_out == 0) chk("rsp_payload_idle", 64'(cfu.rsp_payload_output), 64'h0);
    if (cfu.cmd_valid && cfu.cmd_ready) begin
      chk("core_insn_fwd", 64'(core_insn), 64'(cfu.cmd_payload_instruction));
      chk("core_data_1_fwd", 64'(core_data_1), 64'(cfu.cmd_payload_inputs_0));
      chk("core_data_2_fwd", 64'(core_data_2), 64'(cfu.cmd_payload_inputs_1));
    end
    if (cfu.rsp_valid && cfu.rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_without_cmd", 64'(exp_q.size()), 64'h1);
      else chk("rsp_payload", 64'(cfu.rsp_payload_output), 64'(exp_q.pop_front()));
    end

    if (reset) begin
      m_out  = 0;
      m_owed = 0;
      m_buf  = 0;
      m_err  = 1'b0;
      m_kind_q.delete();
      exp_q.delete();
      core_q.delete();
    end else begin
      acc = cfu.cmd_valid && core_insn_ready && issue_ok;
      pop = exp_valid && cfu.rsp_ready;
      res = core_out_valid && (m_owed > 0);
      if (core_out_valid && m_owed == 0) m_err = 1'b1;
      if (pop) begin
        if (head_scalar) m_buf--;
        void'(m_kind_q.pop_front());
        m_out--;
      end
      if (acc) begin
        m_kind_q.push_back(cur_scalar);
        m_out++;
        if (cur_scalar) m_owed++;
      end
      if (res) begin
        m_owed--;
        m_buf++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cfu.cmd_valid               = 1'b0;
    cfu.cmd_payload_instruction = 32'h0;
    cfu.cmd_payload_inputs_0    = 32'h0;
    cfu.cmd_payload_inputs_1    = 32'h0;
    p_data  = 32'h0;
    p_delay = 0;
    repeat (3) tick();
    reset = 1'b0;
    rsp_ready_fix = 1'b1;
    repeat (2) tick();

    // 1: plain vector op acked with zero the cycle after accept
    send_cmd(0, 32'h0, 0);
    wait_drain(20);

    // 2: vmv.x.s returns the core result
    send_cmd(4, 32'hDEAD_BEEF, 2);
    wait_drain(20);

    // 3: ordering with responses held back
    rsp_ready_fix = 1'b0;
    tick();
    send_cmd(0, 32'h0, 0);
    send_cmd(4, 32'h0000_0005, 3);
    send_cmd(2, 32'h0, 0);
    repeat (8) tick();
    rsp_ready_fix = 1'b1;
    wait_drain(30);

    // 4: order FIFO full blocks the fifth command until a response pops
    rsp_ready_fix = 1'b0;
    tick();
    for (int i = 0; i < ORD_DEPTH; i++) send_cmd(i % 4, 32'h0, 0);
    present(1, 32'h0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ord_full_block", 64'(cfu.cmd_ready), 64'h0);
    end
    rsp_ready_fix = 1'b1;
    wait_accept(20);
    wait_drain(30);

    // 5: result credit exhausted blocks the third scalar command
    rsp_ready_fix = 1'b0;
    core_hold = 1'b1;
    tick();
    send_cmd(4, 32'h1111_0001, 0);
    send_cmd(5, 32'h1111_0002, 0);
    present(4, 32'h1111_0003, 0);
    repeat (3) begin
      @(negedge clk);
      chk("credit_block", 64'(core_insn_valid), 64'h0);
    end
    core_hold = 1'b0;
    repeat (4) tick();
    rsp_ready_fix = 1'b1;
    wait_accept(30);
    wait_drain(30);

    // randomized traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send_cmd($urandom_range(0, 5), $urandom, $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    rsp_ready_fix = 1'b1;
    tick();
    wait_drain(500);

    // 6: reset with two outstanding, then a stray core result
    rsp_ready_fix = 1'b0;
    core_hold = 1'b1;
    tick();
    send_cmd(0, 32'h0, 0);
    send_cmd(4, 32'h2222_0001, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    core_hold = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_valid", 64'(cfu.rsp_valid), 64'h0);
    chk("post_reset_outstanding", 64'(outstanding), 64'h0);
    tick();
    stray_req++;
    repeat (2) tick();
    @(negedge clk);
    chk("stray_err_sticky", 64'(err_unexpected), 64'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("err_cleared_by_reset", 64'(err_unexpected), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
